// File: rtl/multiplier.sv
// Sequential radix-2 shift-add N x N multiplier, signed or unsigned.
// Optional accumulate stage (MADD/MSUB) via `MULTIPLIER_ACC_EN.
module multiplier #(
    parameter int N = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_mulsigned,
    input  logic [N-1:0]     i_multiplicand,
    input  logic [N-1:0]     i_multiplier,
    input  logic             i_mulstart,
    input  logic             i_cancel,
`ifdef MULTIPLIER_ACC_EN
    input  logic             i_acc_en,
    input  logic             i_acc_sub,
    input  logic [2*N-1:0]   i_acc,
`endif
    output logic [2*N-1:0]   o_product,
    output logic             o_busy,
    output logic             o_res_vld
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [N-1:0]   ONE_N  = 1;
    localparam logic [2*N-1:0] ONE_2N = 1;
    localparam logic [CW-1:0]  ONE_C  = 1;
    localparam logic [CW-1:0]  LAST_C = CW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
`ifdef MULTIPLIER_ACC_EN
        S_ACC,
`endif
        S_DONE
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] mcand_q, mcand_d;
    logic [N-1:0]   mplier_q, mplier_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic           neg_q, neg_d;
    logic [2*N-1:0] prod_q, prod_d;
    logic           vld_q, vld_d;
`ifdef MULTIPLIER_ACC_EN
    logic           acc_en_q, acc_en_d;
    logic           acc_sub_q, acc_sub_d;
    logic [2*N-1:0] acc_in_q, acc_in_d;
`endif

    logic           neg_a, neg_b;
    logic [N-1:0]   mag_a, mag_b;

    assign neg_a = i_mulsigned & i_multiplicand[N-1];
    assign neg_b = i_mulsigned & i_multiplier[N-1];
    assign mag_a = neg_a ? (~i_multiplicand + ONE_N) : i_multiplicand;
    assign mag_b = neg_b ? (~i_multiplier + ONE_N) : i_multiplier;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
`ifdef MULTIPLIER_ACC_EN
        acc_en_d  = acc_en_q;
        acc_sub_d = acc_sub_q;
        acc_in_d  = acc_in_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (i_mulstart && !i_cancel) begin
                    mcand_d  = {{N{1'b0}}, mag_a};
                    mplier_d = mag_b;
                    neg_d    = neg_a ^ neg_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_CALC;
`ifdef MULTIPLIER_ACC_EN
                    acc_en_d  = i_acc_en;
                    acc_sub_d = i_acc_sub;
                    acc_in_d  = i_acc;
`endif
                end
            end
            S_CALC: begin
                // Shifted copies stand in for (A << cnt) and B[cnt].
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + ONE_C;
                if (cnt_q == LAST_C) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (neg_q) begin
                    acc_d = ~acc_q + ONE_2N;
                end
`ifdef MULTIPLIER_ACC_EN
                state_d = S_ACC;
`else
                state_d = S_DONE;
`endif
            end
`ifdef MULTIPLIER_ACC_EN
            S_ACC: begin
                if (acc_en_q) begin
                    acc_d = acc_sub_q ? (acc_in_q - acc_q)
                                      : (acc_in_q + acc_q);
                end
                state_d = S_DONE;
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A result that reached DONE is committed; flush only earlier states.
        if (i_cancel && state_q != S_IDLE && state_q != S_DONE) begin
            state_d = S_IDLE;
        end

        vld_d  = (state_d == S_DONE);
        prod_d = vld_d ? acc_d : prod_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            prod_q   <= '0;
            vld_q    <= 1'b0;
`ifdef MULTIPLIER_ACC_EN
            acc_en_q  <= 1'b0;
            acc_sub_q <= 1'b0;
            acc_in_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            prod_q   <= prod_d;
            vld_q    <= vld_d;
`ifdef MULTIPLIER_ACC_EN
            acc_en_q  <= acc_en_d;
            acc_sub_q <= acc_sub_d;
            acc_in_q  <= acc_in_d;
`endif
        end
    end

    assign o_product = prod_q;
    assign o_busy    = (state_q != S_IDLE);
    assign o_res_vld = vld_q;

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for multiplier: vector table plus scoreboard,
// with hand-written cancel, reset, busy-start and accumulate sequences.
module tb_multiplier;

    localparam int N = 32;
`ifdef MULTIPLIER_ACC_EN
    localparam int LAT = N + 3;
`else
    localparam int LAT = N + 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mulsigned;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic        mulstart;
    logic        cancel;
    logic [63:0] product;
    logic        busy;
    logic        res_vld;
`ifdef MULTIPLIER_ACC_EN
    logic        acc_en;
    logic        acc_sub;
    logic [63:0] acc_v;
`endif

    always #5 clk = ~clk;

    multiplier #(.N(N)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_mulsigned    (mulsigned),
        .i_multiplicand (mcand),
        .i_multiplier   (mplier),
        .i_mulstart     (mulstart),
        .i_cancel       (cancel),
`ifdef MULTIPLIER_ACC_EN
        .i_acc_en       (acc_en),
        .i_acc_sub      (acc_sub),
        .i_acc          (acc_v),
`endif
        .o_product      (product),
        .o_busy         (busy),
        .o_res_vld      (res_vld)
    );

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_prod;
    vec_t        tbl[18];

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic sgn,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (sgn) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return sa * sb;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    // Scoreboard: every result pulse must match the oldest expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (res_vld === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_vld", 64'd1, 64'd0);
                end else begin
                    chk("product", product, exp_q.pop_front());
                end
            end
        end
    end

    task automatic set_ops(input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic en,
                           input logic sub, input logic [63:0] acc);
        mulsigned = sgn;
        mcand     = a;
        mplier    = b;
`ifdef MULTIPLIER_ACC_EN
        acc_en  = en;
        acc_sub = sub;
        acc_v   = acc;
`else
        if (en || sub || acc != 64'd0) begin
            chk("acc_args_unused", 64'd1, 64'd0);
        end
`endif
    endtask

    // Start is already driven; E0 is the next edge. poke_at>0 pulses a
    // bogus start with scrambled operands while busy.
    task automatic wait_done(input string nm, input int poke_at);
        int   edges;
        logic busy_ok;
        edges   = 0;
        busy_ok = 1'b1;
        @(posedge clk);
        #1;
        edges    = 1;
        mulstart = 1'b0;
        busy_ok  = busy_ok & busy;
        while (res_vld !== 1'b1 && edges < 200) begin
            if (edges == poke_at) begin
                mulstart = 1'b1;
                mcand    = $urandom;
                mplier   = $urandom;
            end else begin
                mulstart = 1'b0;
            end
            @(posedge clk);
            #1;
            edges++;
            busy_ok = busy_ok & busy;
        end
        mulstart = 1'b0;
        chk({nm, "_latency"}, 64'(edges), 64'(LAT));
        chk({nm, "_busy_held"}, {63'b0, busy_ok}, 64'd1);
        @(posedge clk);
        #1;
        chk({nm, "_busy_drop"}, {63'b0, busy}, 64'd0);
    endtask

    task automatic run_op(input string nm, input logic sgn,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int poke_at);
        @(negedge clk);
        set_ops(sgn, a, b, 1'b0, 1'b0, 64'd0);
        mulstart = 1'b1;
        exp_q.push_back(exp);
        wait_done(nm, poke_at);
        last_prod = exp;
    endtask

    initial begin
        tbl[0] = '{1'b1, 32'hFFFFFFF9, 32'd3,        64'hFFFFFFFF_FFFFFFEB};
        tbl[1] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
        tbl[2] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001};
        tbl[3] = '{1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000};
        tbl[4] = '{1'b1, 32'h00000000, 32'h80000000, 64'h0};
        tbl[5] = '{1'b0, 32'h80000000, 32'd2,        64'h00000001_00000000};
        tbl[6] = '{1'b1, 32'd5,        32'hFFFFFFFA, 64'hFFFFFFFF_FFFFFFE2};
        tbl[7] = '{1'b1, 32'h7FFFFFFF, 32'h80000000, 64'hC0000000_80000000};
        tbl[8] = '{1'b0, 32'hFFFFFFFF, 32'd1,        64'h00000000_FFFFFFFF};
        tbl[9] = '{1'b1, 32'hFFFFFFFF, 32'd1,        64'hFFFFFFFF_FFFFFFFF};
        for (int i = 10; i < 18; i++) begin
            tbl[i].sgn = 1'($urandom_range(0, 1));
            tbl[i].a   = $urandom;
            tbl[i].b   = $urandom;
            tbl[i].exp = model(tbl[i].sgn, tbl[i].a, tbl[i].b);
        end

        rst      = 1'b1;
        mulstart = 1'b0;
        cancel   = 1'b0;
        set_ops(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_product", product, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_vld", {63'b0, res_vld}, 64'd0);
        @(negedge clk);
        rst       = 1'b0;
        last_prod = 64'd0;

        for (int i = 0; i < 18; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].sgn, tbl[i].a,
                   tbl[i].b, tbl[i].exp, 0);
        end

        // Start while busy is ignored; operands stay latched.
        run_op("busy_start", 1'b0, 32'd11, 32'd13, 64'd143, 5);
        repeat (LAT + 4) @(posedge clk);
        #1;
        chk("no_extra_busy", {63'b0, busy}, 64'd0);

        // Cancel at CALC cycle 10, then restart in the very next cycle.
        @(negedge clk);
        set_ops(1'b0, 32'd5, 32'd6, 1'b0, 1'b0, 64'd0);
        mulstart = 1'b1;
        @(posedge clk);
        #1;
        mulstart = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        chk("cancel_busy", {63'b0, busy}, 64'd0);
        chk("cancel_vld", {63'b0, res_vld}, 64'd0);
        chk("cancel_hold", product, last_prod);
        set_ops(1'b0, 32'd9, 32'd9, 1'b0, 1'b0, 64'd0);
        mulstart = 1'b1;
        exp_q.push_back(64'd81);
        wait_done("restart", 0);
        last_prod = 64'd81;

        // Cancel together with start in IDLE: nothing starts.
        @(negedge clk);
        mulstart = 1'b1;
        cancel   = 1'b1;
        @(posedge clk);
        #1;
        mulstart = 1'b0;
        cancel   = 1'b0;
        chk("cancel_start_idle", {63'b0, busy}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("cancel_start_stay", {63'b0, busy}, 64'd0);

        // Reset mid-CALC clears all outputs.
        @(negedge clk);
        set_ops(1'b1, 32'd77, 32'hFFFFFF00, 1'b0, 1'b0, 64'd0);
        mulstart = 1'b1;
        @(posedge clk);
        #1;
        mulstart = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_product", product, 64'd0);
        chk("midrst_busy", {63'b0, busy}, 64'd0);
        chk("midrst_vld", {63'b0, res_vld}, 64'd0);
        last_prod = 64'd0;
        run_op("post_rst", 1'b1, 32'hFFFFFFF9, 32'd3,
               64'hFFFFFFFF_FFFFFFEB, 0);

`ifdef MULTIPLIER_ACC_EN
        @(negedge clk);
        set_ops(1'b0, 32'd6, 32'd7, 1'b1, 1'b1, 64'd100);
        mulstart = 1'b1;
        exp_q.push_back(64'd58);
        wait_done("msub", 0);
        @(negedge clk);
        set_ops(1'b0, 32'd6, 32'd7, 1'b1, 1'b0, 64'd100);
        mulstart = 1'b1;
        exp_q.push_back(64'd142);
        wait_done("madd", 0);
        @(negedge clk);
        set_ops(1'b1, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b1, 64'd100);
        mulstart = 1'b1;
        exp_q.push_back(64'hFFFFFFFF_FFFFFFFA);
        wait_done("acc_off", 0);
        @(negedge clk);
        set_ops(1'b0, 32'd1, 32'd1, 1'b1, 1'b1, 64'd0);
        mulstart = 1'b1;
        exp_q.push_back(64'hFFFFFFFF_FFFFFFFF);
        wait_done("msub_wrap", 0);
        set_ops(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 64'd0);
`endif

        repeat (5) @(posedge clk);
        #1;
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
